nibble_add_sched: RTL and testbench
===================================

Name: nibble_add_sched

Overview:
- Shares one 4-bit nibble adder (ripple carry, with carry-in) between two requesters.
- Performs WIDTH-bit additions one nibble per cycle, least-significant nibble first, holding the carry in a register between nibbles.
- A round-robin arbiter picks the requester. A 3-state FSM sequences the nibbles and holds the result on a valid/ready response port.
- Sits between operand producers and consumers in place of a wide combinational adder when area matters more than latency.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived number of nibble steps per operation. Not overridable.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ0_VALID  input  1  requester 0 has operands.
- REQ0_READY  output  1  requester 0 operands accepted this cycle.
- REQ0_A  input  WIDTH  requester 0 operand A.
- REQ0_B  input  WIDTH  requester 0 operand B.
- REQ1_VALID  input  1  requester 1 has operands.
- REQ1_READY  output  1  requester 1 operands accepted this cycle.
- REQ1_A  input  WIDTH  requester 1 operand A.
- REQ1_B  input  WIDTH  requester 1 operand B.
- RSP_VALID  output  1  result available.
- RSP_READY  input  1  consumer takes result.
- RSP_ID  output  1  index of the requester that owns the result.
- RSP_SUM  output  WIDTH  A+B modulo 2^WIDTH.
- RSP_COUT  output  1  carry out of the MSB.
- BUSY  output  1  high in ADD or DONE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; RSP_VALID=0, RSP_ID=0, RSP_SUM=0, RSP_COUT=0, BUSY=0.
  - Carry register=0, nibble counter=0, round-robin pointer=0 (REQ0 has priority on the first contest).
  - Reset asserted mid-operation aborts it with no response. Released operands are not retried internally; the requester must re-present them.
- States: IDLE, ADD, DONE.
- IDLE:
  - REQx_READY is combinational and high only in IDLE for the granted requester.
  - Grant rule: if only one VALID is high, grant it. If both are high, grant the one the pointer does not point to as last served (pointer 0 means REQ1 wins, pointer 1 means REQ0 wins). Exception: immediately after reset the pointer is 0, but REQ0 wins the first contest; implement as a "none served yet" flag.
  - On the accept edge:
    - Latch A, B and the requester ID; clear carry and counter.
    - Update the pointer to the granted ID.
    - Go to ADD.
  - No READY may go high outside IDLE. VALID with no READY leaves the operands pending; no state change.
- ADD:
  - Each edge computes nibble k of A+B+carry using the nibble adder.
  - Writes the 4-bit sum into RSP_SUM[4k+3:4k], updates the carry, increments the counter.
  - After the edge that processes nibble NIB-1: go to DONE, RSP_VALID=1, RSP_COUT=final carry.
- Latency: with accept at edge E0, RSP_VALID is high from edge E_NIB onward (4 edges for WIDTH=16).
- RSP_SUM bits not yet written during ADD are don't-care; the bench checks only when RSP_VALID=1.
- DONE:
  - RSP_VALID, RSP_SUM, RSP_COUT and RSP_ID stay stable until RSP_READY=1.
  - On the handshake edge: RSP_VALID=0, go to IDLE. A new accept can happen on the next edge at the earliest; no same-cycle turnaround.
  - RSP_READY is ignored when RSP_VALID=0.
- Arithmetic:
  - Unsigned sum; carry propagates across nibbles exactly as in a full ripple.
  - The final RSP_SUM/RSP_COUT equal {COUT,SUM} = A+B over WIDTH+1 bits.
- Throughput: at most one operation per NIB+2 cycles when the consumer is always ready.

Test Plan:
- Single op, WIDTH=16: REQ0 A=0x1234, B=0x4321, RSP_READY=1 -> RSP_VALID 4 edges after accept, RSP_SUM=0x5555, RSP_COUT=0, RSP_ID=0.
- Full carry chain: REQ1 A=0xFFFF, B=0x0001 -> RSP_SUM=0x0000, RSP_COUT=1, RSP_ID=1. Also A=0x8000, B=0x8000 -> SUM=0x0000, COUT=1.
- Contention: both VALID held high with distinct operands (REQ0 0x0001+0x0001, REQ1 0x0002+0x0002) -> first grant REQ0 (SUM 0x0002), then REQ1 (SUM 0x0004), then REQ0 again. Never two READY high in the same cycle.
- Backpressure: hold RSP_READY=0 for 5 cycles after RSP_VALID -> outputs stable, both READY=0, BUSY=1. Raise RSP_READY -> IDLE next edge; the pending request is accepted the edge after.
- Reset mid-op: assert RST_N=0 during ADD (after 2 nibbles) -> RSP_VALID=0, BUSY=0, RSP_SUM=0 immediately. After release, a re-presented 0x00FF+0x0001 yields 0x0100, COUT=0.
- Random: 1000 ops with random VALID/READY and operands -> every result matches a reference A+B. Every accepted request gets exactly one response with the correct RSP_ID.

Source files
------------

// File: rtl/nibble_add_sched.sv
// Two-requester WIDTH-bit adder built around one shared 4-bit ripple adder.
// Round-robin grant, one nibble per cycle, result held on a valid/ready port.
module nibble_add_sched #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             busy
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             id_q, id_d, cout_q, cout_d, carry_q, carry_d;
   logic             ptr_q, ptr_d, served_q, served_d;
   logic             gnt0, gnt1;
   logic [3:0]       nib_a, nib_b, nib_s;
   logic             nib_co;

   // REQ0 wins a tie before anyone has been served, or when REQ1 was served last.
   always_comb begin
      gnt0 = req0_valid && (!req1_valid || !served_q || ptr_q);
      gnt1 = req1_valid && !gnt0;
   end

   assign req0_ready = (state_q == StIdle) && gnt0;
   assign req1_ready = (state_q == StIdle) && gnt1;

   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int k = 0; k < NIB; k++) begin
         if (cnt_q == CntW'(k)) begin
            nib_a = a_q[4*k +: 4];
            nib_b = b_q[4*k +: 4];
         end
      end
   end

   always_comb begin : ripple
      logic c;
      c = carry_q;
      nib_s = '0;
      for (int i = 0; i < 4; i++) begin
         nib_s[i] = nib_a[i] ^ nib_b[i] ^ c;
         c        = (nib_a[i] & nib_b[i]) | (c & (nib_a[i] ^ nib_b[i]));
      end
      nib_co = c;
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      cout_d   = cout_q;
      carry_d  = carry_q;
      ptr_d    = ptr_q;
      served_d = served_q;
      case (state_q)
         StIdle: begin
            if (gnt0 || gnt1) begin
               a_d      = gnt1 ? req1_a : req0_a;
               b_d      = gnt1 ? req1_b : req0_b;
               id_d     = gnt1;
               ptr_d    = gnt1;
               served_d = 1'b1;
               carry_d  = 1'b0;
               cnt_d    = '0;
               state_d  = StAdd;
            end
         end
         StAdd: begin
            for (int k = 0; k < NIB; k++) begin
               if (cnt_q == CntW'(k)) sum_d[4*k +: 4] = nib_s;
            end
            carry_d = nib_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntW'(NIB - 1)) begin
               cnt_d   = '0;
               cout_d  = nib_co;
               state_d = StDone;
            end
         end
         StDone: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         id_q     <= 1'b0;
         cout_q   <= 1'b0;
         carry_q  <= 1'b0;
         ptr_q    <= 1'b0;
         served_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
         cout_q   <= cout_d;
         carry_q  <= carry_d;
         ptr_q    <= ptr_d;
         served_q <= served_d;
      end
   end

   assign rsp_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_id    = id_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Randomised and directed bench for nibble_add_sched against a plain A+B / round-robin model.
module tb_nibble_add_sched;

   localparam int W = 16;

   logic         clk, rst_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
   logic [W-1:0] rsp_sum;

   int n_checks = 0;
   int n_errors = 0;

   // Arbitration model: who was served last, and whether anyone has been yet.
   bit mdl_served = 0;
   bit mdl_last   = 0;

   typedef struct packed {
      logic        id;
      logic [W:0]  sum;
   } exp_t;

   nibble_add_sched #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_a    (req0_a),
      .req0_b    (req0_b),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_a    (req1_a),
      .req1_b    (req1_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .busy      (busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic bit mdl_grant(input bit v0, input bit v1);
      if (v0 && !v1) return 1'b0;
      if (v1 && !v0) return 1'b1;
      if (!mdl_served) return 1'b0;
      return !mdl_last;
   endfunction

   task automatic do_reset();
      rst_n = 0;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      mdl_served = 0;
      mdl_last   = 0;
   endtask

   // Drive one op on requester id with the consumer always ready; results handed back.
   task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] s, output logic c, output logic rid,
                         output int lat, output bit ok);
      bit got;
      got = 0; ok = 0; lat = -1; s = '0; c = 0; rid = 0;
      rsp_ready = 1;
      @(negedge clk);
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; end
      for (int i = 0; i < 20; i++) begin
         #1;
         if (id ? req1_ready : req0_ready) begin got = 1; break; end
         @(negedge clk);
      end
      if (!got) begin
         req0_valid = 0; req1_valid = 0;
         return;
      end
      mdl_served = 1; mdl_last = id;
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rsp_valid) begin
            s = rsp_sum; c = rsp_cout; rid = rsp_id; lat = i; ok = 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0;
      req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({rsp_valid, busy, rsp_id, rsp_cout} !== 4'b0) begin
         n_errors++;
         $display("FAIL reset_flags: got valid/busy/id/cout=%b%b%b%b exp 0000",
                  rsp_valid, busy, rsp_id, rsp_cout);
      end
      n_checks++;
      if (rsp_sum !== 16'h0000) begin
         n_errors++; $display("FAIL reset_sum: got %h exp 0000", rsp_sum);
      end
      rst_n = 1;
      mdl_served = 0; mdl_last = 0;
      @(negedge clk); #1;
      n_checks++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0) begin
         n_errors++;
         $display("FAIL reset_idle: got rdy0/rdy1/busy/valid=%b%b%b%b exp 0000",
                  req0_ready, req1_ready, busy, rsp_valid);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] s; logic c, rid; int lat; bit ok;
      run_op(0, 16'h1234, 16'h4321, s, c, rid, lat, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL single_timeout: got no response exp one"); end
      n_checks++;
      if (lat !== 4) begin n_errors++; $display("FAIL single_latency: got %0d exp 4", lat); end
      n_checks++;
      if ({rid, c, s} !== {1'b0, 1'b0, 16'h5555}) begin
         n_errors++;
         $display("FAIL single_result: got id=%b cout=%b sum=%h exp id=0 cout=0 sum=5555",
                  rid, c, s);
      end
   endtask

   task automatic test_carry_chain();
      logic [W-1:0] s; logic c, rid; int lat; bit ok;
      run_op(1, 16'hFFFF, 16'h0001, s, c, rid, lat, ok);
      n_checks++;
      if (!ok || {rid, c, s} !== {1'b1, 1'b1, 16'h0000}) begin
         n_errors++;
         $display("FAIL carry_ffff: got ok=%b id=%b cout=%b sum=%h exp id=1 cout=1 sum=0000",
                  ok, rid, c, s);
      end
      run_op(0, 16'h8000, 16'h8000, s, c, rid, lat, ok);
      n_checks++;
      if (!ok || {rid, c, s} !== {1'b0, 1'b1, 16'h0000}) begin
         n_errors++;
         $display("FAIL carry_8000: got ok=%b id=%b cout=%b sum=%h exp id=0 cout=1 sum=0000",
                  ok, rid, c, s);
      end
   endtask

   task automatic test_contention();
      bit           exp_id  [3];
      logic [W-1:0] exp_sum [3];
      int           nresp, ngrant;
      bit           g;
      exp_id = '{1'b0, 1'b1, 1'b0};
      exp_sum = '{16'h0002, 16'h0004, 16'h0002};
      nresp = 0; ngrant = 0;
      do_reset();
      @(negedge clk);
      req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0001;
      req1_valid = 1; req1_a = 16'h0002; req1_b = 16'h0002;
      rsp_ready = 1;
      for (int cyc = 0; cyc < 60 && nresp < 3; cyc++) begin
         #1;
         n_checks++;
         if (req0_ready && req1_ready) begin
            n_errors++; $display("FAIL contend_two_ready: got both ready exp at most one");
         end
         if (req0_ready ^ req1_ready) begin
            g = req1_ready;
            n_checks++;
            if (g !== mdl_grant(1'b1, 1'b1)) begin
               n_errors++;
               $display("FAIL contend_grant: got %0d exp %0d", g, mdl_grant(1'b1, 1'b1));
            end
            mdl_served = 1; mdl_last = g; ngrant++;
         end
         if (rsp_valid) begin
            n_checks++;
            if ({rsp_id, rsp_cout, rsp_sum} !== {exp_id[nresp], 1'b0, exp_sum[nresp]}) begin
               n_errors++;
               $display("FAIL contend_rsp%0d: got id=%b sum=%h exp id=%b sum=%h", nresp,
                        rsp_id, rsp_sum, exp_id[nresp], exp_sum[nresp]);
            end
            nresp++;
            if (nresp == 3) begin req0_valid = 0; req1_valid = 0; end
         end
         @(negedge clk);
      end
      req0_valid = 0; req1_valid = 0;
      n_checks++;
      if (nresp != 3) begin
         n_errors++; $display("FAIL contend_timeout: got %0d responses exp 3", nresp);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit got;
      got = 0;
      rsp_ready = 0;
      @(negedge clk);
      req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req0_ready) begin got = 1; break; end
         @(negedge clk);
      end
      mdl_served = 1; mdl_last = 0;
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_a = 16'h0F0F; req1_b = 16'h0101;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rsp_valid) begin got = 1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!got) begin n_errors++; $display("FAIL bp_timeout: got no response exp one"); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_cout, rsp_sum, req0_ready, req1_ready, busy} !==
             {1'b1, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL bp_hold%0d: got v=%b id=%b sum=%h r0=%b r1=%b busy=%b exp 1 0 3333 0 0 1",
                     i, rsp_valid, rsp_id, rsp_sum, req0_ready, req1_ready, busy);
         end
         @(negedge clk); #1;
      end
      rsp_ready = 1;
      @(negedge clk); #1;
      n_checks++;
      if ({rsp_valid, busy, req1_ready} !== 3'b001) begin
         n_errors++;
         $display("FAIL bp_release: got valid=%b busy=%b rdy1=%b exp 0 0 1",
                  rsp_valid, busy, req1_ready);
      end
      mdl_served = 1; mdl_last = 1;
      @(negedge clk);
      req1_valid = 0;
      #1;
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL bp_accept: got busy=%b exp 1", busy); end
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) begin got = 1; break; end
         @(negedge clk); #1;
      end
      n_checks++;
      if (!got || {rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b0, 16'h1010}) begin
         n_errors++;
         $display("FAIL bp_pending: got ok=%b id=%b sum=%h exp id=1 sum=1010", got, rsp_id, rsp_sum);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      logic [W-1:0] s; logic c, rid; int lat; bit ok;
      rsp_ready = 1;
      @(negedge clk);
      req0_valid = 1; req0_a = 16'hAAAA; req0_b = 16'h5555;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req0_ready) break;
         @(negedge clk);
      end
      @(negedge clk);
      req0_valid = 0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy_before: got %b exp 1", busy); end
      rst_n = 0;
      #1;
      n_checks++;
      if ({rsp_valid, busy, rsp_sum} !== {1'b0, 1'b0, 16'h0000}) begin
         n_errors++;
         $display("FAIL midrst_clear: got valid=%b busy=%b sum=%h exp 0 0 0000",
                  rsp_valid, busy, rsp_sum);
      end
      @(negedge clk);
      rst_n = 1;
      mdl_served = 0; mdl_last = 0;
      run_op(0, 16'h00FF, 16'h0001, s, c, rid, lat, ok);
      n_checks++;
      if (!ok || {rid, c, s} !== {1'b0, 1'b0, 16'h0100}) begin
         n_errors++;
         $display("FAIL midrst_reissue: got ok=%b id=%b cout=%b sum=%h exp id=0 cout=0 sum=0100",
                  ok, rid, c, s);
      end
   endtask

   task automatic test_random();
      bit           pend [2];
      logic [W-1:0] pa [2], pb [2];
      exp_t         q [$];
      exp_t         e;
      int           ncreated, naccepted, nresp;
      bit           g;
      pend = '{0, 0};
      ncreated = 0; naccepted = 0; nresp = 0;
      do_reset();
      for (int cyc = 0; cyc < 40000 && nresp < 1000; cyc++) begin
         @(negedge clk);
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && ncreated < 1000 && $urandom_range(0, 2) != 0) begin
               pend[r] = 1;
               pa[r] = W'($urandom);
               pb[r] = ($urandom_range(0, 7) == 0) ? ~pa[r] : W'($urandom);
               ncreated++;
            end
         end
         req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0];
         req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1];
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_checks++;
         if (req0_ready && req1_ready) begin
            n_errors++; $display("FAIL rand_two_ready: cycle %0d got both ready exp one", cyc);
         end
         if (req0_ready ^ req1_ready) begin
            g = req1_ready;
            n_checks++;
            if (!(pend[0] || pend[1]) || g !== mdl_grant(pend[0], pend[1])) begin
               n_errors++;
               $display("FAIL rand_grant: cycle %0d got %0d exp %0d (pend %b%b)", cyc, g,
                        mdl_grant(pend[0], pend[1]), pend[1], pend[0]);
            end
            e.id  = g;
            e.sum = {1'b0, pa[g]} + {1'b0, pb[g]};
            q.push_back(e);
            pend[g] = 0;
            mdl_served = 1; mdl_last = g;
            naccepted++;
         end
         if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++; $display("FAIL rand_spurious: got response exp none");
            end else begin
               e = q.pop_front();
               if ({rsp_id, rsp_cout, rsp_sum} !== {e.id, e.sum}) begin
                  n_errors++;
                  $display("FAIL rand_rsp%0d: got id=%b cout=%b sum=%h exp id=%b cout=%b sum=%h",
                           nresp, rsp_id, rsp_cout, rsp_sum, e.id, e.sum[W], e.sum[W-1:0]);
               end
            end
            nresp++;
         end
      end
      req0_valid = 0; req1_valid = 0;
      n_checks++;
      if (nresp != 1000 || naccepted != 1000 || q.size() != 0) begin
         n_errors++;
         $display("FAIL rand_count: got resp=%0d acc=%0d left=%0d exp 1000 1000 0",
                  nresp, naccepted, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_carry_chain();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
